// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings for the SRAM-to-AXI3 bridge: size codes, burst type, IDs and FSM states.
package sram_axi_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [3:0] DEF_INST_ID = 4'd0;
    localparam logic [3:0] DEF_DATA_ID = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } bridge_state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } bridge_port_e;

endpackage

// File: rtl/sram_axi_bridge_wstrb_gen.sv
// Byte-lane strobe from access size and address offset; data is not shifted, only lanes are selected.
module sram_axi_bridge_wstrb_gen
    import sram_axi_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] offset,
    output logic [3:0] wstrb
);

    always_comb begin
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << offset;
            SIZE_HALF: wstrb = 4'b0011 << offset;
            default:   wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU fetch and data SRAM-like ports onto one AXI3 master, one transaction at a time.
//   state      | meaning
//   ST_IDLE    | no transaction; arbitrate and accept a request
//   ST_RD_REQ  | arvalid high, waiting for arready
//   ST_RD_WAIT | rready high, waiting for the read beat
//   ST_WR_REQ  | awvalid/wvalid raised, each dropping on its own handshake
//   ST_WR_WAIT | bready high, waiting for the write response
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter bit         DATA_FIRST = 1'b1,
    parameter logic [3:0] INST_ID    = DEF_INST_ID,
    parameter logic [3:0] DATA_ID    = DEF_DATA_ID
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    bridge_state_e state_q;
    bridge_port_e  port_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          aw_done_q;
    logic          w_done_q;

    logic idle;
    logic grant_inst;
    logic grant_data;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic unused_axi;

    // Grants are qualified by resetn so no addr_ok can escape while reset is held.
    assign idle       = resetn && (state_q == ST_IDLE);
    assign grant_data = idle && data_req && (DATA_FIRST || !inst_req);
    assign grant_inst = idle && inst_req && (!DATA_FIRST || !data_req);

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    assign r_hs  = rready && rvalid;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign inst_data_ok = r_hs && (port_q == PORT_INST);
    assign data_data_ok = (r_hs && (port_q == PORT_DATA)) || (bready && bvalid);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = (port_q == PORT_DATA) ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;

    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;

    sram_axi_bridge_wstrb_gen u_wstrb_gen (
        .size   (size_q),
        .offset (addr_q[1:0]),
        .wstrb  (wstrb)
    );

    // Single-beat responses: IDs, response codes and rlast carry no extra information here.
    assign unused_axi = ^{rid, rresp, rlast, bid, bresp, wr_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_INST;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_data || grant_inst) begin
                        port_q    <= grant_data ? PORT_DATA : PORT_INST;
                        wr_q      <= grant_data && data_wr;
                        size_q    <= grant_data ? data_size : SIZE_WORD;
                        addr_q    <= grant_data ? data_addr : inst_addr;
                        wdata_q   <= grant_data ? data_wdata : 32'd0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (grant_data && data_wr) begin
                            state_q <= ST_WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state_q <= ST_RD_REQ;
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid   <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid   <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // Either channel may finish first, or both in the same cycle.
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready  <= 1'b1;
                        state_q <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed and randomized checks of sram_axi_bridge against a byte-lane memory model and an AXI slave.
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wstrb;

    int tests_run = 0;
    int tests_failed = 0;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference memory model ----------------
    logic [31:0] ref_mem   [logic [29:0]];
    logic [31:0] slave_mem [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[13:0], 2'b01, ~w[15:0]};
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        return ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : init_word(addr[31:2]);
    endfunction

    function automatic logic [3:0] ref_strobe(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        int first;
        logic [3:0] s;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        first  = (nbytes == 4) ? 0 : int'(addr[1:0]);
        s = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= first && i < first + nbytes) s[i] = 1'b1;
        return s;
    endfunction

    task automatic ref_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] w;
        logic [3:0]  s;
        w = ref_read(addr);
        s = ref_strobe(size, addr);
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = wd[8*i +: 8];
        ref_mem[addr[31:2]] = w;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        ref_mem[addr[31:2]]   = val;
        slave_mem[addr[31:2]] = val;
    endtask

    // ---------------- AXI slave (acts on the falling edge) ----------------
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
    bit r_pend, aw_got, w_got, b_pend;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [3:0]  last_arid, last_awid, last_wid;
    logic [2:0]  last_arsize, last_awsize;
    logic [7:0]  last_arlen, last_awlen;
    logic [1:0]  last_arburst, last_awburst;
    logic        last_wlast;

    function automatic logic [31:0] slave_read(input logic [29:0] w);
        return slave_mem.exists(w) ? slave_mem[w] : init_word(w);
    endfunction

    initial begin : axi_slave
        logic [31:0] merged;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = '0; rid = 4'd0; rresp = 2'd0; rlast = 1'b1; bid = 4'd1; bresp = 2'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (ar_fire) begin arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
                if (r_fire)  begin rvalid = 0; r_pend = 0; end
                if (aw_fire) begin awready = 0; aw_cnt = 0; aw_got = 1; end
                if (w_fire)  begin wready = 0; w_cnt = 0; w_got = 1; end
                if (b_fire)  begin bvalid = 0; b_pend = 0; end
                if (aw_got && w_got) begin
                    merged = slave_read(cap_awaddr[31:2]);
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) merged[8*i +: 8] = cap_wdata[8*i +: 8];
                    slave_mem[cap_awaddr[31:2]] = merged;
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end
                if (arvalid && !arready) begin
                    if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
                end
                if (r_pend && !rvalid) begin
                    if (r_cnt >= r_delay) begin rvalid = 1; rdata = slave_read(cap_araddr[31:2]); end
                    else r_cnt++;
                end
                if (awvalid && !awready) begin
                    if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
                end
                if (wvalid && !wready) begin
                    if (w_cnt >= w_delay) wready = 1; else w_cnt++;
                end
                if (b_pend && !bvalid) begin
                    if (b_cnt >= b_delay) bvalid = 1; else b_cnt++;
                end
                ar_fire = arvalid && arready;
                if (ar_fire) begin
                    cap_araddr = araddr; last_arid = arid; last_arsize = arsize;
                    last_arlen = arlen; last_arburst = arburst;
                end
                r_fire  = rvalid && rready;
                aw_fire = awvalid && awready;
                if (aw_fire) begin
                    cap_awaddr = awaddr; last_awid = awid; last_awsize = awsize;
                    last_awlen = awlen; last_awburst = awburst;
                end
                w_fire = wvalid && wready;
                if (w_fire) begin
                    cap_wdata = wdata; cap_wstrb = wstrb; last_wid = wid; last_wlast = wlast;
                end
                b_fire = bvalid && bready;
            end
        end
    end

    // ---------------- CPU-side transfer ----------------
    task automatic cpu_xfer(input bit is_inst, input bit wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output bit accepted, output bit done, output logic [31:0] rd,
                            output int lat, output int wrong_ok);
        int n;
        accepted = 0; done = 0; rd = '0; lat = 0; wrong_ok = 0; n = 0;
        @(negedge clk);
        if (is_inst) begin
            inst_req = 1'b1; inst_addr = addr;
        end else begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        end
        while (!accepted && n < 60) begin
            #2;
            accepted = is_inst ? inst_addr_ok : data_addr_ok;
            @(negedge clk);
            n++;
        end
        if (is_inst) inst_req = 1'b0; else data_req = 1'b0;
        while (accepted && !done && lat < 60) begin
            #2;
            lat++;
            if (is_inst ? data_data_ok : inst_data_ok) wrong_ok++;
            if (is_inst ? inst_data_ok : data_data_ok) begin
                done = 1;
                rd = is_inst ? inst_rdata : data_rdata;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        bit          acc, dn;
        logic [31:0] rd;
        int          lat, wrong;
        logic [3:0]  obs_sig [1:8];
        logic [3:0]  exp_sig [1:8];
        int          pulses, dok, iok, idok, rr;
        logic [31:0] rdv, irdv;
        bit          r_inst, r_wr;
        logic [1:0]  r_size, r_off;
        logic [31:0] r_addr, r_wd;

        resetn = 1'b0;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = '0; data_wdata = '0;

        // reset state, including an inst_req held during reset
        @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #2;
        check("rst_valid_ready", {arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        check("rst_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        @(negedge clk); inst_req = 1'b0;
        @(negedge clk); resetn = 1'b1;

        // inst read, zero-wait
        preload(32'hBFC0_0000, 32'h3C1D_0001);
        @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; #2;
        check("ird_addr_ok_c0", inst_addr_ok, 1);
        @(negedge clk); inst_req = 1'b0; #2;
        check("ird_arvalid_c1", arvalid, 1);
        check("ird_arid_c1", arid, 0);
        check("ird_araddr_c1", araddr, 32'hBFC0_0000);
        check("ird_arfmt_c1", {arsize, arlen, arburst}, {3'd2, 8'd0, 2'b01});
        @(negedge clk); #2;
        check("ird_data_ok_c2", inst_data_ok, 1);
        check("ird_rdata_c2", inst_rdata, 32'h3C1D_0001);
        @(negedge clk); #2;
        check("ird_idle_c3", {inst_data_ok, arvalid, rready}, 0);

        // simultaneous requests: data wins, inst follows after data_data_ok
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000; #2;
        check("arb_grant_c0", {data_addr_ok, inst_addr_ok}, 2'b10);
        @(negedge clk); data_req = 1'b0; #2;
        check("arb_arid_c1", arid, 1);
        check("arb_araddr_c1", araddr, 32'h8000_1000);
        check("arb_no_inst_c1", inst_addr_ok, 0);
        @(negedge clk); #2;
        check("arb_data_ok_c2", data_data_ok, 1);
        check("arb_rdata_c2", data_rdata, ref_read(32'h8000_1000));
        check("arb_no_inst_c2", inst_addr_ok, 0);
        @(negedge clk); #2;
        check("arb_inst_ok_c3", inst_addr_ok, 1);
        @(negedge clk); inst_req = 1'b0; #2;
        check("arb_inst_arid_c4", {arvalid, arid}, {1'b1, 4'd0});
        @(negedge clk); #2;
        check("arb_inst_data_c5", {inst_data_ok, inst_rdata}, {1'b1, ref_read(32'hBFC0_0004)});

        // byte / half / word stores
        cpu_xfer(0, 1, 2'd1, 32'h8000_0002, 32'hBEEF_BEEF, acc, dn, rd, lat, wrong);
        ref_write(2'd1, 32'h8000_0002, 32'hBEEF_BEEF);
        check("sth_done", {acc, dn}, 2'b11);
        check("sth_wstrb", last_wstrb_or(cap_wstrb), 4'b1100);
        check("sth_awsize", last_awsize, 3'd1);
        cpu_xfer(0, 1, 2'd0, 32'h8000_0003, 32'h5A5A_5A5A, acc, dn, rd, lat, wrong);
        ref_write(2'd0, 32'h8000_0003, 32'h5A5A_5A5A);
        check("stb_done", {acc, dn}, 2'b11);
        check("stb_wstrb", cap_wstrb, 4'b1000);
        check("stb_awsize", last_awsize, 3'd0);
        check("stb_awaddr", cap_awaddr, 32'h8000_0003);
        check("stb_ids", {last_awid, last_wid, last_wlast, last_awlen, last_awburst},
              {4'd1, 4'd1, 1'b1, 8'd0, 2'b01});
        cpu_xfer(0, 1, 2'd2, 32'h8000_0004, 32'hCAFE_F00D, acc, dn, rd, lat, wrong);
        ref_write(2'd2, 32'h8000_0004, 32'hCAFE_F00D);
        check("stw_wstrb", cap_wstrb, 4'b1111);
        check("stw_awsize", last_awsize, 3'd2);
        check("stw_lat", lat, 2);
        cpu_xfer(0, 0, 2'd2, 32'h8000_0000, 32'h0, acc, dn, rd, lat, wrong);
        check("st_readback0", rd, ref_read(32'h8000_0000));
        cpu_xfer(0, 0, 2'd2, 32'h8000_0004, 32'h0, acc, dn, rd, lat, wrong);
        check("st_readback4", rd, ref_read(32'h8000_0004));

        // awready delayed 3 cycles, wready immediate
        aw_delay = 3;
        exp_sig = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0008;
        data_wdata = 32'h0BAD_F00D; #2;
        check("awdly_addr_ok", data_addr_ok, 1);
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); data_req = 1'b0; #2;
            obs_sig[c] = {awvalid, wvalid, bready, data_data_ok};
            if (data_data_ok) pulses++;
        end
        for (int c = 1; c <= 8; c++)
            check($sformatf("awdly_c%0d", c), obs_sig[c], exp_sig[c]);
        check("awdly_pulses", pulses, 1);
        ref_write(2'd2, 32'h8000_0008, 32'h0BAD_F00D);
        aw_delay = 0;

        // rvalid delayed 5 cycles with a pending inst_req
        r_delay = 5;
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0008; #2;
        check("rdly_addr_ok", data_addr_ok, 1);
        dok = 0; iok = 0; idok = 0; rr = 0; rdv = '0; irdv = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            data_req = 1'b0;
            inst_req = (iok == 0);
            inst_addr = 32'hBFC0_0000;
            #2;
            if (data_data_ok && dok == 0) begin dok = c; rdv = data_rdata; r_delay = 0; end
            if (inst_addr_ok && iok == 0) iok = c;
            if (inst_data_ok && idok == 0) begin idok = c; irdv = inst_rdata; end
            if (rready && c >= 2 && c <= 7) rr++;
        end
        inst_req = 1'b0;
        check("rdly_data_ok_cyc", dok, 7);
        check("rdly_rdata", rdv, ref_read(32'h8000_0008));
        check("rdly_rready_cycles", rr, 6);
        check("rdly_inst_addr_ok_cyc", iok, 8);
        check("rdly_inst_data_ok_cyc", idok, 10);
        check("rdly_inst_rdata", irdv, 32'h3C1D_0001);

        // reset while in WR_REQ
        aw_delay = 20;
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0200;
        data_wdata = 32'h1234_5678; #2;
        check("wrst_addr_ok", data_addr_ok, 1);
        @(negedge clk); data_req = 1'b0; #2;
        check("wrst_valids_c1", {awvalid, wvalid}, 2'b11);
        @(negedge clk); #2;
        check("wrst_valids_c2", {awvalid, wvalid, bready}, 3'b100);
        #1; resetn = 1'b0; #1;
        check("wrst_async_drop", {awvalid, wvalid, bready, arvalid, rready}, 0);
        @(negedge clk); @(negedge clk); resetn = 1'b1; aw_delay = 0;
        cpu_xfer(0, 0, 2'd2, 32'h8000_0200, 32'h0, acc, dn, rd, lat, wrong);
        check("wrst_read_done", {acc, dn}, 2'b11);
        check("wrst_read_data", rd, ref_read(32'h8000_0200));
        check("wrst_read_lat", lat, 2);

        // randomized traffic against the reference memory
        for (int k = 0; k < 40; k++) begin
            r_inst = ($urandom_range(0, 3) == 0);
            r_wr   = !r_inst && ($urandom_range(0, 1) == 1);
            r_size = r_inst ? 2'd2 : 2'($urandom_range(0, 2));
            r_off  = (r_size == 2'd2) ? 2'd0 :
                     (r_size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
            r_addr = 32'h8000_0100 + 32'($urandom_range(0, 7)) * 4 + {30'd0, r_off};
            r_wd   = $urandom();
            ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 3);
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 2);
            cpu_xfer(r_inst, r_wr, r_size, r_addr, r_wd, acc, dn, rd, lat, wrong);
            check($sformatf("rnd%0d_done", k), {acc, dn}, 2'b11);
            check($sformatf("rnd%0d_other_port_ok", k), wrong, 0);
            check($sformatf("rnd%0d_lat_min", k), (lat >= 2), 1);
            if (r_wr) begin
                check($sformatf("rnd%0d_wstrb", k), cap_wstrb, ref_strobe(r_size, r_addr));
                check($sformatf("rnd%0d_awsize", k), last_awsize, {1'b0, r_size});
                ref_write(r_size, r_addr, r_wd);
            end else begin
                check($sformatf("rnd%0d_rdata", k), rd, ref_read(r_addr));
                check($sformatf("rnd%0d_arid", k), last_arid, r_inst ? 4'd0 : 4'd1);
                check($sformatf("rnd%0d_arsize", k), last_arsize, {1'b0, r_size});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    function automatic logic [3:0] last_wstrb_or(input logic [3:0] s);
        return s;
    endfunction

endmodule
